// File: rtl/arb_pkg.sv
// Shared definitions for the four-channel round-robin arbiter:
// channel count, index width, FSM state encoding and a one-hot helper.
package arb_pkg;

  localparam int N_CH = 4;
  localparam int ID_W = 2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  function automatic logic [N_CH-1:0] id_to_onehot(input logic [ID_W-1:0] id);
    return N_CH'(1) << id;
  endfunction

endpackage

// File: rtl/rr_pick_4.sv
// Combinational rotating-priority selector: the first set request at or after
// ptr (wrapping 3->0) wins.
module rr_pick_4
  import arb_pkg::*;
(
  input  logic [N_CH-1:0] req,
  input  logic [ID_W-1:0] ptr,
  output logic [ID_W-1:0] win_id,
  output logic            win_valid
);

  logic [2*N_CH-1:0] req_dbl;
  logic [N_CH-1:0]   req_rot;
  logic [ID_W-1:0]   off;

  // Doubling the vector turns the rotate-right into a plain shift.
  assign req_dbl = {req, req};
  assign req_rot = N_CH'(req_dbl >> ptr);

  // NOTE: every combinational output gets a default before any conditional
  // assignment, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    off = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (req_rot[i]) off = ID_W'(i);
    end
  end

  // Adding ptr back relies on the 2-bit wrap to map the offset to a channel.
  assign win_id    = off + ptr;
  assign win_valid = |req;

endmodule

// File: rtl/arbiter_rr_4.sv
// Four-requester round-robin arbiter: two-state FSM, registered one-hot and
// encoded grant, optional hold timeout that force-releases a stuck owner.
module arbiter_rr_4
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] req,
  input  logic            done,
  output logic [N_CH-1:0] gnt,
  output logic [ID_W-1:0] gnt_id,
  output logic            gnt_valid,
  output logic            timeout
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  state_e            state_q, state_d;
  logic [N_CH-1:0]   gnt_q, gnt_d;
  logic [ID_W-1:0]   gnt_id_q, gnt_id_d;
  logic              gnt_valid_q, gnt_valid_d;
  logic              timeout_q, timeout_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0]  hold_cnt_q, hold_cnt_d;

  logic [ID_W-1:0]   win_id;
  logic              win_valid;
  logic              owner_release;
  logic              hold_expired;

  rr_pick_4 u_pick (
    .req      (req),
    .ptr      (ptr_q),
    .win_id   (win_id),
    .win_valid(win_valid)
  );

  // Only the owner's request bit matters while granted; others cannot pre-empt.
  assign owner_release = done || !req[gnt_id_q];
  assign hold_expired  = (MAX_HOLD != 0) && (hold_cnt_q == HOLD_LAST);

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    gnt_id_d    = gnt_id_q;
    gnt_valid_d = gnt_valid_q;
    timeout_d   = 1'b0;
    ptr_d       = ptr_q;
    hold_cnt_d  = hold_cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (win_valid) begin
          state_d     = ST_GRANT;
          gnt_d       = id_to_onehot(win_id);
          gnt_id_d    = win_id;
          gnt_valid_d = 1'b1;
          hold_cnt_d  = '0;
        end
      end
      ST_GRANT: begin
        if (owner_release || hold_expired) begin
          state_d     = ST_IDLE;
          gnt_d       = '0;
          gnt_valid_d = 1'b0;
          ptr_d       = ID_W'(gnt_id_q + 1'b1);
          // A voluntary release in the same cycle suppresses the timeout flag.
          timeout_d   = !owner_release;
        end else begin
          hold_cnt_d  = hold_cnt_q + 1'b1;
        end
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      gnt_q       <= '0;
      gnt_id_q    <= '0;
      gnt_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
      ptr_q       <= '0;
      hold_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      gnt_id_q    <= gnt_id_d;
      gnt_valid_q <= gnt_valid_d;
      timeout_q   <= timeout_d;
      ptr_q       <= ptr_d;
      hold_cnt_q  <= hold_cnt_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_id    = gnt_id_q;
  assign gnt_valid = gnt_valid_q;
  assign timeout   = timeout_q;

endmodule

// File: doc/arbiter_rr_4.md
Name: arbiter_rr_4

Overview:
- Four-requester round-robin arbiter that grants one shared resource at a time.
- Grant is presented both one-hot and as a 2-bit encoded index with a valid flag, matching the encoded-output convention of the encoder family.
- Sits between four bus masters and a single shared datapath (memory port or encoder bank); the owner holds the grant until it signals done.
- An optional hold timeout stops a stuck owner from starving the others.

Parameters:
- MAX_HOLD, default 16: maximum cycles a grant may be held before forced release; 0 disables the timeout.
- CNT_W, default 5: width of the hold counter; must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- req  input  4  request per channel, level-sensitive; bit i = channel i
- done  input  1  current owner releases the resource (sampled only in GRANT)
- gnt  output  4  one-hot grant, registered
- gnt_id  output  2  encoded index of the granted channel
- gnt_valid  output  1  high while any grant is active
- timeout  output  1  one-cycle pulse when a grant is force-released

Behaviour:
- Reset (async, rst_n=0): state=IDLE, gnt=4'b0000, gnt_id=2'b00, gnt_valid=0, timeout=0, ptr=2'd0, hold_cnt=0.
- Reset takes effect immediately, even mid-grant. After release, channel 0 has highest priority.
- States: IDLE and GRANT, two-state FSM, all outputs registered.

IDLE:
- If req != 0, select the winner by rotating priority starting at ptr: check ptr, ptr+1, ptr+2, ptr+3 (mod 4); the first set bit wins.
- At the next edge: state=GRANT, gnt=one-hot(winner), gnt_id=winner, gnt_valid=1, hold_cnt=0.
- Latency from req to gnt is 1 cycle.
- If req == 0, remain in IDLE with all grant outputs 0.

GRANT:
- Normal release occurs when done=1 or req[gnt_id]=0. At the next edge: state=IDLE, gnt=0, gnt_valid=0, ptr=gnt_id+1 (mod 4, wraps 3->0).
- Otherwise hold_cnt increments each cycle.
- Forced release occurs when MAX_HOLD!=0 and hold_cnt==MAX_HOLD-1 with no release condition. It has the same effect as a normal release, plus timeout=1 for exactly one cycle.
- If a normal release and a timeout coincide in the same cycle, the normal release wins and timeout stays 0.
- gnt_id keeps its last value in IDLE. Consumers must qualify it with gnt_valid.
- There is a minimum of one IDLE cycle between consecutive grants. Back-to-back grants to different channels are therefore spaced 2 cycles apart.
- Changes on req in GRANT do not pre-empt the owner. Only the owner's req bit is observed.
- done while in IDLE is ignored.
- Fairness: any continuously asserted request is granted within 3 intervening grants.

Decomposition:
- Shared package arb_pkg holds:
  - state encoding constants ST_IDLE=1'b0, ST_GRANT=1'b1
  - channel-count constant N_CH=4
  - index width ID_W=2
- Sub-module rr_pick_4 is the combinational rotating priority selector.
  - Inputs: req[3:0], ptr[1:0].
  - Outputs: win_id[1:0], win_valid.
  - Implementation: rotate req right by ptr, fixed-priority encode, add ptr back mod 4.
  - It is independently testable against all 64 input combinations.
- The top level contains the FSM, hold counter and output registers.

Test Plan:
- Reset then req=4'b1010 -> 1 cycle later gnt=4'b0010, gnt_id=1, gnt_valid=1. done pulse -> next cycle gnt=0, ptr=2; following grant is gnt=4'b1000, gnt_id=3.
- req held at 4'b1111, owner asserts done 2 cycles after each grant -> grant order is 0,1,2,3,0 with gnt_id wrapping 3->0, and one idle cycle between grants.
- MAX_HOLD=4, req=4'b0100, done never asserted -> gnt=4'b0100 for exactly 4 cycles, then gnt=0 with timeout=1 for one cycle; grant re-issued to channel 2 after 1 idle cycle.
- Owner drops req mid-grant (req 4'b0001->4'b0000, no done) -> next cycle gnt=0, gnt_valid=0, timeout=0, ptr=1.
- In GRANT, assert rst_n=0 asynchronously between clock edges -> gnt=0, gnt_valid=0, timeout=0 immediately. After release with req=4'b1001, the grant goes to channel 0.
- done and timeout coincide (MAX_HOLD=3, done at the 3rd grant cycle) -> release with timeout=0. Also: done asserted while in IDLE with req=0 -> no output change.
